// File: rtl/test_sequencer.sv
// test_sequencer: run controller for core-level simulation and FPGA bring-up.
// Holds the core in reset for RST_CYCLES after start, then counts run cycles
// and retired instructions. The run ends on exit, on a pc stall or on the
// cycle watchdog. The result is reported on registered status outputs.
`timescale 1ns/1ps
module test_sequencer #(
   parameter int XLEN        = 32,
   parameter int GP_W        = 3,
   parameter int PASS_GP     = 1,
   parameter int RST_CYCLES  = 4,
   parameter int MAX_CYCLES  = 4096,
   parameter int STALL_LIMIT = 64,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              exit,
   input  logic [GP_W-1:0]   gp,
   input  logic [XLEN-1:0]   pc,
   input  logic              retire,
   output logic              core_rst_n,
   output logic              running,
   output logic              done,
   output logic [1:0]        status,
   output logic              hang,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [GP_W-1:0]   gp_final
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int WD_W  = $clog2(MAX_CYCLES + 1);
   localparam int ST_W  = $clog2(STALL_LIMIT + 1);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_CYCLES - 1);
   localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STALL_LIMIT - 1);
   localparam logic [GP_W-1:0]  PASS_VAL = GP_W'(PASS_GP);

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_PASS = 2'b01;
   localparam logic [1:0] ST_FAIL = 2'b10;
   localparam logic [1:0] ST_HANG = 2'b11;

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [RST_W-1:0] rst_cnt;
   logic [WD_W-1:0]  wd_cnt;     // non-saturating run length for the watchdog
   logic [ST_W-1:0]  stall_cnt;
   logic [XLEN-1:0]  prev_pc;

   logic pc_changed;
   logic stall_hit;
   logic timeout_hit;

   // Exit-condition qualifiers for the current RUN cycle; wd_cnt==0 marks the
   // first RUN cycle, which has no valid previous pc and counts as changed.
   always_comb begin
      pc_changed  = (wd_cnt == '0) || (pc != prev_pc);
      stall_hit   = !pc_changed && (stall_cnt == ST_LAST);
      timeout_hit = (wd_cnt == WD_LAST);
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_HOLD;
         rst_cnt    <= '0;
         wd_cnt     <= '0;
         stall_cnt  <= '0;
         prev_pc    <= '0;
         core_rst_n <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
         status     <= ST_NONE;
         hang       <= 1'b0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         gp_final   <= '0;
      end else if (restart) begin
         state      <= S_HOLD;
         rst_cnt    <= '0;
         wd_cnt     <= '0;
         stall_cnt  <= '0;
         prev_pc    <= '0;
         core_rst_n <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
         status     <= ST_NONE;
         hang       <= 1'b0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         gp_final   <= '0;
      end else begin
         case (state)
            S_HOLD: begin
               if (rst_cnt == RST_LAST) begin
                  state      <= S_RUN;
                  core_rst_n <= 1'b1;
                  running    <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            S_RUN: begin
               wd_cnt  <= wd_cnt + 1'b1;
               prev_pc <= pc;
               if (cycle_cnt != '1)
                  cycle_cnt <= cycle_cnt + 1'b1;
               if (retire && (retire_cnt != '1))
                  retire_cnt <= retire_cnt + 1'b1;
               if (pc_changed)
                  stall_cnt <= '0;
               else
                  stall_cnt <= stall_cnt + 1'b1;
               if (exit || stall_hit || timeout_hit) begin
                  state    <= S_DONE;
                  running  <= 1'b0;
                  done     <= 1'b1;
                  gp_final <= gp;
               end
               if (exit) begin
                  status <= (gp == PASS_VAL) ? ST_PASS : ST_FAIL;
                  hang   <= 1'b0;
               end else if (stall_hit) begin
                  status <= ST_HANG;
                  hang   <= 1'b1;
               end else if (timeout_hit) begin
                  status <= ST_HANG;
                  hang   <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: randomized and directed bench for test_sequencer with a
// behavioural reference model (phase, run length, unchanged-pc streak).
`timescale 1ns/1ps
module tb_test_sequencer;

   localparam int XLEN        = 32;
   localparam int GP_W        = 3;
   localparam int PASS_GP     = 1;
   localparam int RST_CYCLES  = 4;
   localparam int MAX_CYCLES  = 100;
   localparam int STALL_LIMIT = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic restart = 1'b0;
   logic ex = 1'b0;
   logic [GP_W-1:0] gp = '0;
   logic [XLEN-1:0] pc = '0;
   logic retire = 1'b0;

   logic a_core_rst_n, a_running, a_done, a_hang;
   logic [1:0] a_status;
   logic [31:0] a_cycle_cnt, a_retire_cnt;
   logic [GP_W-1:0] a_gp_final;

   logic b_core_rst_n, b_running, b_done, b_hang;
   logic [1:0] b_status;
   logic [3:0] b_cycle_cnt, b_retire_cnt;
   logic [GP_W-1:0] b_gp_final;

   int pass_cnt = 0;
   int tot_cnt = 0;

   // Reference model state
   int m_phase;   // 0 = core held in reset, 1 = running, 2 = finished
   int m_hold, m_run, m_ret, m_streak, m_status, m_hang, m_gpf;
   logic [XLEN-1:0] m_prev;

   test_sequencer #(.XLEN(XLEN), .GP_W(GP_W), .PASS_GP(PASS_GP), .RST_CYCLES(RST_CYCLES),
                    .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .restart(restart), .exit(ex), .gp(gp), .pc(pc), .retire(retire),
      .core_rst_n(a_core_rst_n), .running(a_running), .done(a_done), .status(a_status),
      .hang(a_hang), .cycle_cnt(a_cycle_cnt), .retire_cnt(a_retire_cnt), .gp_final(a_gp_final));

   test_sequencer #(.XLEN(XLEN), .GP_W(GP_W), .PASS_GP(PASS_GP), .RST_CYCLES(RST_CYCLES),
                    .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .restart(restart), .exit(ex), .gp(gp), .pc(pc), .retire(retire),
      .core_rst_n(b_core_rst_n), .running(b_running), .done(b_done), .status(b_status),
      .hang(b_hang), .cycle_cnt(b_cycle_cnt), .retire_cnt(b_retire_cnt), .gp_final(b_gp_final));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1);
   end

   task automatic model_reset();
      m_phase = 0; m_hold = 0; m_run = 0; m_ret = 0; m_streak = 0;
      m_status = 0; m_hang = 0; m_gpf = 0; m_prev = '0;
   endtask

   // Predicts the state after the next clock edge from the inputs applied now.
   task automatic model_step(input bit r, input bit e, input int g, input logic [XLEN-1:0] p,
                             input bit ret);
      if (r) begin
         model_reset();
      end else if (m_phase == 0) begin
         m_hold++;
         if (m_hold == RST_CYCLES) m_phase = 1;
      end else if (m_phase == 1) begin
         m_run++;
         if (ret) m_ret++;
         if (m_run == 1 || p != m_prev) m_streak = 0; else m_streak++;
         m_prev = p;
         if (e) begin
            m_status = (g == PASS_GP) ? 1 : 2; m_hang = 0; m_phase = 2; m_gpf = g;
         end else if (m_streak == STALL_LIMIT) begin
            m_status = 3; m_hang = 1; m_phase = 2; m_gpf = g;
         end else if (m_run == MAX_CYCLES) begin
            m_status = 3; m_hang = 0; m_phase = 2; m_gpf = g;
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input logic [GP_W-1:0] g,
                       input logic [XLEN-1:0] p, input bit ret);
      restart = r; ex = e; gp = g; pc = p; retire = ret;
      model_step(r, e, int'(g), p, ret);
      @(posedge clk);
      #1;
   endtask

   task automatic bring_up();
      step(1'b1, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b0, '0, 32'h10 + i, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #3;
      tot_cnt++; if (a_core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n got=%b exp=0", a_core_rst_n); else pass_cnt++;
      tot_cnt++; if (a_running !== 1'b0) $display("FAIL rst_running got=%b exp=0", a_running); else pass_cnt++;
      tot_cnt++; if (a_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", a_done); else pass_cnt++;
      tot_cnt++; if (a_status !== 2'b00 || a_hang !== 1'b0) $display("FAIL rst_status got=%b/%b exp=00/0", a_status, a_hang); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd0 || a_retire_cnt !== 32'd0) $display("FAIL rst_counters got=%0d/%0d exp=0/0", a_cycle_cnt, a_retire_cnt); else pass_cnt++;
      tot_cnt++; if (a_gp_final !== 3'd0) $display("FAIL rst_gp_final got=%0d exp=0", a_gp_final); else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < RST_CYCLES; i++) begin
         step(1'b0, 1'b0, '0, 32'h20 + i, 1'b0);
         tot_cnt++;
         if (a_core_rst_n !== (i == RST_CYCLES - 1) || a_running !== (i == RST_CYCLES - 1))
            $display("FAIL rst_release_edge%0d got core_rst_n=%b running=%b exp=%b", i + 1,
                     a_core_rst_n, a_running, i == RST_CYCLES - 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_pass_exit();
      logic [9:0] pat;
      pat = 10'b1011011101;
      for (int i = 0; i < 10; i++)
         step(1'b0, i == 9, (i == 9) ? 3'd1 : 3'd0, 32'h100 + 4 * i, pat[i]);
      tot_cnt++; if (a_status !== 2'b01 || a_done !== 1'b1 || a_running !== 1'b0) $display("FAIL pass_status got=%b done=%b run=%b exp=01/1/0", a_status, a_done, a_running); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd10) $display("FAIL pass_cycle_cnt got=%0d exp=10", a_cycle_cnt); else pass_cnt++;
      tot_cnt++; if (a_retire_cnt !== 32'd7) $display("FAIL pass_retire_cnt got=%0d exp=7", a_retire_cnt); else pass_cnt++;
      tot_cnt++; if (a_gp_final !== 3'd1 || a_core_rst_n !== 1'b1) $display("FAIL pass_gp_final got=%0d core_rst_n=%b exp=1/1", a_gp_final, a_core_rst_n); else pass_cnt++;
   endtask

   task automatic test_fail_exit();
      bring_up();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd1, 32'h200 + 4 * i, 1'b0);
      step(1'b0, 1'b1, 3'd3, 32'h300, 1'b0);
      tot_cnt++; if (a_status !== 2'b10 || a_gp_final !== 3'd3) $display("FAIL fail_status got=%b gp=%0d exp=10/3", a_status, a_gp_final); else pass_cnt++;
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom), $urandom, 1'b1);
      tot_cnt++; if (a_status !== 2'b10 || a_gp_final !== 3'd3 || a_done !== 1'b1) $display("FAIL fail_frozen got=%b gp=%0d done=%b exp=10/3/1", a_status, a_gp_final, a_done); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd6 || a_retire_cnt !== 32'd0 || a_core_rst_n !== 1'b1) $display("FAIL fail_frozen_cnt got=%0d/%0d core_rst_n=%b exp=6/0/1", a_cycle_cnt, a_retire_cnt, a_core_rst_n); else pass_cnt++;
   endtask

   task automatic test_stall();
      bring_up();
      for (int i = 0; i < 200 && !a_done; i++) step(1'b0, 1'b0, 3'd0, 32'h44, 1'b0);
      tot_cnt++; if (a_done !== 1'b1 || a_status !== 2'b11 || a_hang !== 1'b1) $display("FAIL stall_detect got done=%b status=%b hang=%b exp=1/11/1", a_done, a_status, a_hang); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd65) $display("FAIL stall_cycle_cnt got=%0d exp=65", a_cycle_cnt); else pass_cnt++;
   endtask

   task automatic test_timeout();
      bring_up();
      for (int i = 0; i < 200 && !a_done; i++)
         step(1'b0, 1'b0, 3'd0, (i % 2) ? 32'h80 : 32'h84, 1'b1);
      tot_cnt++; if (a_done !== 1'b1 || a_status !== 2'b11 || a_hang !== 1'b0) $display("FAIL timeout_detect got done=%b status=%b hang=%b exp=1/11/0", a_done, a_status, a_hang); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd100 || a_retire_cnt !== 32'd100) $display("FAIL timeout_cnt got=%0d/%0d exp=100/100", a_cycle_cnt, a_retire_cnt); else pass_cnt++;
      tot_cnt++; if (b_cycle_cnt !== 4'd15 || b_retire_cnt !== 4'd15) $display("FAIL sat_cnt got=%0d/%0d exp=15/15", b_cycle_cnt, b_retire_cnt); else pass_cnt++;
      tot_cnt++; if (b_done !== 1'b1 || b_status !== 2'b11 || b_hang !== 1'b0) $display("FAIL sat_watchdog got done=%b status=%b hang=%b exp=1/11/0", b_done, b_status, b_hang); else pass_cnt++;
   endtask

   task automatic test_exit_timeout();
      logic [GP_W-1:0] g;
      logic [1:0] exp_st;
      for (int k = 0; k < 2; k++) begin
         g = (k == 0) ? 3'(PASS_GP) : 3'($urandom_range(2, 7));
         exp_st = (k == 0) ? 2'b01 : 2'b10;
         bring_up();
         for (int i = 0; i < MAX_CYCLES; i++)
            step(1'b0, i == MAX_CYCLES - 1, g, (i % 2) ? 32'h90 : 32'h94, 1'b0);
         tot_cnt++; if (a_status !== exp_st || a_hang !== 1'b0 || a_gp_final !== g) $display("FAIL exit_vs_timeout%0d got status=%b hang=%b gp=%0d exp=%b/0/%0d", k, a_status, a_hang, a_gp_final, exp_st, g); else pass_cnt++;
      end
   endtask

   task automatic test_restart();
      int bad;
      step(1'b1, 1'b1, 3'd1, 32'h0, 1'b1);
      tot_cnt++; if (a_core_rst_n !== 1'b0 || a_done !== 1'b0 || a_running !== 1'b0 || a_status !== 2'b00 || a_hang !== 1'b0) $display("FAIL restart_flags got core=%b done=%b run=%b st=%b hang=%b exp=0/0/0/00/0", a_core_rst_n, a_done, a_running, a_status, a_hang); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd0 || a_retire_cnt !== 32'd0 || a_gp_final !== 3'd0) $display("FAIL restart_counters got=%0d/%0d/%0d exp=0/0/0", a_cycle_cnt, a_retire_cnt, a_gp_final); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
         if (a_core_rst_n !== 1'b0) bad++;
      end
      tot_cnt++; if (bad != 0) $display("FAIL restart_held got %0d cycles with core_rst_n=1 exp=0", bad); else pass_cnt++;
      for (int i = 0; i < RST_CYCLES; i++) begin
         step(1'b0, 1'b1, 3'd1, 32'h400 + i, 1'b1);
         tot_cnt++;
         if (a_core_rst_n !== (i == RST_CYCLES - 1) || a_status !== 2'b00 || a_done !== 1'b0)
            $display("FAIL restart_hold_edge%0d got core=%b status=%b done=%b exp=%b/00/0", i + 1,
                     a_core_rst_n, a_status, a_done, i == RST_CYCLES - 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      bring_up();
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 3'd0, 32'h500 + 4 * i, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      tot_cnt++; if (a_core_rst_n !== 1'b0 || a_running !== 1'b0) $display("FAIL async_rst_flags got core=%b run=%b exp=0/0", a_core_rst_n, a_running); else pass_cnt++;
      tot_cnt++; if (a_cycle_cnt !== 32'd0 || a_retire_cnt !== 32'd0) $display("FAIL async_rst_counters got=%0d/%0d exp=0/0", a_cycle_cnt, a_retire_cnt); else pass_cnt++;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
      tot_cnt++; if (a_running !== 1'b1 || a_core_rst_n !== 1'b1) $display("FAIL async_rst_rerun got run=%b core=%b exp=1/1", a_running, a_core_rst_n); else pass_cnt++;
   endtask

   task automatic test_random();
      int hold_pct[6] = '{0, 50, 98, 99, 97, 20};
      logic [XLEN-1:0] cur_pc;
      logic [72:0] got, exp;
      logic [3:0] exp_b;
      int errs;
      cur_pc = 32'h1000;
      for (int run = 0; run < 6; run++) begin
         bring_up();
         errs = 0;
         for (int i = 0; i < 170; i++) begin
            if ($urandom_range(0, 99) >= hold_pct[run]) cur_pc = $urandom;
            step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 59) == 0), 3'($urandom),
                 cur_pc, 1'($urandom_range(0, 1)));
            got = {a_core_rst_n, a_running, a_done, a_status, a_hang, a_cycle_cnt, a_retire_cnt, a_gp_final};
            exp = {m_phase != 0, m_phase == 1, m_phase == 2, 2'(m_status), 1'(m_hang),
                   32'(m_run), 32'(m_ret), 3'(m_gpf)};
            exp_b = (m_run > 15) ? 4'd15 : 4'(m_run);
            tot_cnt++;
            if (got !== exp || b_cycle_cnt !== exp_b) begin
               if (errs < 5)
                  $display("FAIL random_run%0d_cyc%0d got=%h/%0d exp=%h/%0d", run, i, got, b_cycle_cnt, exp, exp_b);
               errs++;
            end else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_pass_exit();
      test_fail_exit();
      test_stall();
      test_timeout();
      test_exit_timeout();
      test_restart();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
